// File: rtl/gen_audio_dds.sv
// gen_audio_dds
//   Multi-channel DDS tone generator for the HDMI audio sample path.
//   Each channel has a phase accumulator, a quarter-wave sine ROM, a click-free
//   volume ramp (one LSB per tick) and a mute. Samples are two's complement or
//   offset binary, and are registered so downstream logic may read them at any
//   time.
//
//   Ports
//     I_clk_audio   in   1                 block clock
//     I_reset_n     in   1                 asynchronous active-low reset
//     I_tick        in   1                 sample strobe, 1-cycle pulse, >= 4 clocks apart
//     I_phase_sync  in   1                 zero all phase accumulators (on a tick only)
//     I_phase_inc   in   NUM_CH*PHASE_W    per-channel phase increment, ch0 in LSBs
//     I_volume      in   NUM_CH*8          per-channel target volume (255 = unity)
//     I_mute        in   NUM_CH            per-channel mute (target volume forced to 0)
//     O_sample      out  NUM_CH*SAMPLE_W   per-channel sample, ch0 in LSBs
//     O_valid       out  1                 1-cycle pulse when O_sample updates
//
//   Handshake: I_tick is a one-cycle strobe with no backpressure; it launches a
//   token through a fixed 3-stage pipeline. O_valid is a one-cycle qualifier that
//   rises exactly 3 clocks after I_tick; O_sample changes only on that cycle and
//   is held otherwise.
//
//   Pipeline
//     S1 (tick)   capture phase, advance accumulator, step volume toward target
//     S2          quadrant fold + ROM lookup + sign
//     S3          volume scale, output format, register O_sample / O_valid

module gen_audio_dds #(
  parameter int NUM_CH     = 2,
  parameter int SAMPLE_W   = 16,
  parameter int PHASE_W    = 24,
  parameter int LUT_ADDR_W = 6,
  parameter bit SIGNED_OUT = 1'b1
) (
  input  logic                         I_clk_audio,
  input  logic                         I_reset_n,
  input  logic                         I_tick,
  input  logic                         I_phase_sync,
  input  logic [NUM_CH*PHASE_W-1:0]    I_phase_inc,
  input  logic [NUM_CH*8-1:0]          I_volume,
  input  logic [NUM_CH-1:0]            I_mute,
  output logic [NUM_CH*SAMPLE_W-1:0]   O_sample,
  output logic                         O_valid
);

  localparam int N  = 1 << LUT_ADDR_W;
  // ROM entries never reach full scale, so the sign bit is not stored.
  localparam int LW = SAMPLE_W - 1;

  localparam logic [SAMPLE_W-1:0] RST_SAMPLE =
    SIGNED_OUT ? '0 : (SAMPLE_W'(1) << (SAMPLE_W - 1));

  typedef logic [N*LW-1:0] lut_t;

  // Builds the quarter-wave table at elaboration time:
  //   LUT[k] = round((2^(SAMPLE_W-1)-1) * sin(pi/2 * (k+0.5)/N))
  // sin() is a Taylor series in Q30 fixed point; the residual error is far
  // below half an LSB, so the rounding lands on the same integer as an exact
  // evaluation. Only the resulting constant reaches hardware.
  function automatic lut_t build_lut();
    lut_t   t;
    longint pi_q, x, x2, term, acc, amp, val;
    t    = '0;
    pi_q = 64'd3373259426;                      // pi * 2^30
    amp  = (longint'(1) << (SAMPLE_W - 1)) - 1;
    for (int k = 0; k < N; k++) begin
      x    = (pi_q * longint'(2 * k + 1)) / longint'(4 * N);
      x2   = (x * x) >>> 30;
      term = x;
      acc  = x;
      for (int n = 1; n <= 8; n++) begin
        term = (term * x2) >>> 30;
        term = term / longint'((2 * n) * (2 * n + 1));
        acc  = (n % 2 == 1) ? acc - term : acc + term;
      end
      val = (amp * acc + (longint'(1) << 29)) >>> 30;
      t[k*LW +: LW] = LW'(val);
    end
    return t;
  endfunction

  localparam lut_t LUT = build_lut();

  // Pipeline tokens: only a tick moves data forward.
  logic v1, v2;

  always_ff @(posedge I_clk_audio or negedge I_reset_n) begin
    if (!I_reset_n) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      O_valid <= 1'b0;
    end else begin
      v1      <= I_tick;
      v2      <= v1;
      O_valid <= v2;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [PHASE_W-1:0]         phase, p1;
    logic [7:0]                 cur, cur_next, tgt, vol1, vol2;
    logic [LUT_ADDR_W-1:0]      a, addr;
    logic [LW-1:0]              v;
    logic signed [SAMPLE_W-1:0] s, s2;
    logic signed [9:0]          g;
    logic signed [SAMPLE_W+8:0] prod;
    logic [SAMPLE_W-1:0]        y, out_r;
    logic                       unused_bits;

    // Volume ramp: move one step toward the target per tick so level changes
    // and mutes never produce a click.
    always_comb begin
      tgt      = I_mute[c] ? 8'd0 : I_volume[c*8 +: 8];
      cur_next = cur;
      if (cur < tgt)      cur_next = cur + 8'd1;
      else if (cur > tgt) cur_next = cur - 8'd1;
    end

    // S1: the sample for this tick uses the pre-update phase and the
    // already-stepped volume.
    always_ff @(posedge I_clk_audio or negedge I_reset_n) begin
      if (!I_reset_n) begin
        phase <= '0;
        p1    <= '0;
        cur   <= '0;
        vol1  <= '0;
      end else if (I_tick) begin
        p1    <= phase;
        phase <= I_phase_sync ? '0 : phase + I_phase_inc[c*PHASE_W +: PHASE_W];
        cur   <= cur_next;
        vol1  <= cur_next;
      end
    end

    // S2: top two phase bits select the quadrant; odd quadrants read the
    // table mirrored, the lower half-cycle is negated.
    always_comb begin
      a    = p1[PHASE_W-3 -: LUT_ADDR_W];
      addr = p1[PHASE_W-2] ? ~a : a;
      v    = LUT[int'(addr)*LW +: LW];
      s    = signed'({1'b0, v});
      if (p1[PHASE_W-1]) s = -s;
    end

    always_ff @(posedge I_clk_audio or negedge I_reset_n) begin
      if (!I_reset_n) begin
        s2   <= '0;
        vol2 <= '0;
      end else if (v1) begin
        s2   <= s;
        vol2 <= vol1;
      end
    end

    // S3: 255 maps to a gain of 256 so unity passes the sample unchanged.
    // Taking bits [SAMPLE_W+7:8] of the signed product is the floor shift.
    always_comb begin
      g    = (vol2 == 8'd255) ? 10'sd256 : signed'({2'b00, vol2});
      prod = (SAMPLE_W+9)'(s2) * (SAMPLE_W+9)'(g);
      y    = prod[SAMPLE_W+7:8];
    end

    always_ff @(posedge I_clk_audio or negedge I_reset_n) begin
      if (!I_reset_n) begin
        out_r <= RST_SAMPLE;
      end else if (v2) begin
        out_r <= SIGNED_OUT ? y : {~y[SAMPLE_W-1], y[SAMPLE_W-2:0]};
      end
    end

    assign O_sample[c*SAMPLE_W +: SAMPLE_W] = out_r;

    // Phase fraction below the table address and the product bits dropped by
    // the shift are intentionally discarded.
    assign unused_bits = ^{p1[PHASE_W-3-LUT_ADDR_W:0], prod[7:0], prod[SAMPLE_W+8]};
  end

endmodule

// File: tb/tb_gen_audio_dds.sv
// Bench for gen_audio_dds (NUM_CH=2, SAMPLE_W=16, PHASE_W=24, LUT_ADDR_W=6).
// A second instance with offset-binary output shares all inputs.
module tb_gen_audio_dds;

  localparam logic [31:0] OFFS = 32'h8000_8000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        tick = 1'b0;
  logic        sync = 1'b0;
  logic [47:0] phase_inc = '0;
  logic [15:0] volume = '0;
  logic [1:0]  mute = '0;
  logic [31:0] sample, sample_ob;
  logic        valid, valid_ob;

  gen_audio_dds dut (
    .I_clk_audio (clk),
    .I_reset_n   (rst_n),
    .I_tick      (tick),
    .I_phase_sync(sync),
    .I_phase_inc (phase_inc),
    .I_volume    (volume),
    .I_mute      (mute),
    .O_sample    (sample),
    .O_valid     (valid)
  );

  gen_audio_dds #(.SIGNED_OUT(1'b0)) dut_ob (
    .I_clk_audio (clk),
    .I_reset_n   (rst_n),
    .I_tick      (tick),
    .I_phase_sync(sync),
    .I_phase_inc (phase_inc),
    .I_volume    (volume),
    .I_mute      (mute),
    .O_sample    (sample_ob),
    .O_valid     (valid_ob)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model state / scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  int          lut_m [64];
  longint      ph [2];
  int          cur_m [2];
  logic [23:0] inc_v [2];
  logic [7:0]  vol_v [2];
  logic [1:0]  mute_v;
  logic [31:0] exp_q [$];
  int          exp_t_q [$];
  logic [31:0] held;
  logic [31:0] last_exp;
  int          qv [4] = '{402, 32765, -402, -32765};

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Sample value straight from the definition: quadrant fold, ROM, sign, gain.
  function automatic logic [15:0] model_sample(input longint p, input int cur);
    int q, a, addr, s, g;
    q    = int'(p / 64'd4194304);
    a    = int'((p / 64'd65536) % 64);
    addr = (q % 2 == 1) ? 63 - a : a;
    s    = (q >= 2) ? -lut_m[addr] : lut_m[addr];
    g    = (cur == 255) ? 256 : cur;
    return 16'($rtoi($floor(real'(s * g) / 256.0)));
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      ph[ch]    = 0;
      cur_m[ch] = 0;
    end
    exp_q.delete();
    exp_t_q.delete();
    held = '0;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      bit ev;
      ev = (exp_t_q.size() > 0) && (exp_t_q[0] == cyc);
      checks++;
      if (valid !== ev) begin
        errors++;
        $display("FAIL valid cyc=%0d got %b want %b", cyc, valid, ev);
      end
      checks++;
      if (valid_ob !== ev) begin
        errors++;
        $display("FAIL valid_ob cyc=%0d got %b want %b", cyc, valid_ob, ev);
      end
      if (ev) begin
        held = exp_q.pop_front();
        void'(exp_t_q.pop_front());
      end
      checks++;
      if (sample !== held) begin
        errors++;
        $display("FAIL sample cyc=%0d got %h want %h", cyc, sample, held);
      end
      checks++;
      if (sample_ob !== (held ^ OFFS)) begin
        errors++;
        $display("FAIL sample_ob cyc=%0d got %h want %h", cyc, sample_ob, held ^ OFFS);
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1, at least 4 cycles after the tick.
  task automatic do_tick(input bit s, input int n_idle, output logic [31:0] out);
    logic [31:0] e;
    int          t0;
    bit          seen;
    phase_inc = {inc_v[1], inc_v[0]};
    volume    = {vol_v[1], vol_v[0]};
    mute      = mute_v;
    sync      = s;
    tick      = 1'b1;
    for (int ch = 0; ch < 2; ch++) begin
      longint p;
      int     tgt;
      p      = ph[ch];
      ph[ch] = s ? 0 : (ph[ch] + longint'(inc_v[ch])) % 64'd16777216;
      tgt    = mute_v[ch] ? 0 : int'(vol_v[ch]);
      if (cur_m[ch] < tgt)      cur_m[ch]++;
      else if (cur_m[ch] > tgt) cur_m[ch]--;
      e[ch*16 +: 16] = model_sample(p, cur_m[ch]);
    end
    exp_q.push_back(e);
    exp_t_q.push_back(cyc + 3);
    last_exp = e;
    t0 = cyc;
    @(posedge clk); #1;
    tick = 1'b0;
    sync = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (valid) seen = 1'b1;
    end
    if (!seen) chk("latency_timeout", 0, 1);
    else       chk("latency", cyc - t0, 3);
    out = sample;
    @(posedge clk); #1;
    // Phase sync without a tick must be ignored.
    repeat (n_idle) begin
      sync = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    sync = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] o;
    int          prev, cur_o;

    for (int k = 0; k < 64; k++)
      lut_m[k] = $rtoi($floor(32767.0 * $sin(3.14159265358979323846 * (real'(k) + 0.5) / 128.0) + 0.5));
    chk("lut0", lut_m[0], 402);
    chk("lut63", lut_m[63], 32765);

    model_reset();
    inc_v[0] = 24'h400000;
    inc_v[1] = 24'($urandom);
    vol_v[0] = 8'd255;
    vol_v[1] = 8'd255;
    mute_v   = 2'b00;

    // Reset values, applied without a clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_sample", sample, 0);
    chk("rst_valid", valid, 0);
    chk("rst_sample_ob", sample_ob, OFFS);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Ramp from 0 to unity in exactly 255 ticks.
    for (int n = 1; n <= 256; n++) begin
      do_tick(1'b0, 0, o);
      if (n == 1)   chk("ramp_t1", $signed(o[15:0]), 1);
      if (n == 2)   chk("ramp_t2", $signed(o[15:0]), 255);
      if (n == 254) chk("ramp_t254", $signed(o[15:0]), 32509);
      if (n == 256) chk("ramp_unity", $signed(o[15:0]), -32765);
    end

    // Quadrant folding after a sync.
    do_tick(1'b1, 0, o);
    for (int i = 0; i < 8; i++) begin
      do_tick(1'b0, $urandom_range(0, 2), o);
      chk("quad", $signed(o[15:0]), qv[i % 4]);
    end

    // Mute ramp-down at the crest (phase parked at quadrant 1, addr 63).
    do_tick(1'b1, 0, o);
    do_tick(1'b0, 0, o);
    inc_v[0]  = '0;
    mute_v[0] = 1'b1;
    prev = 32767;
    for (int n = 1; n <= 256; n++) begin
      do_tick(1'b0, 0, o);
      cur_o = $signed(o[15:0]);
      checks++;
      if (cur_o > prev) begin
        errors++;
        $display("FAIL mute_monotonic got %0d want <= %0d", cur_o, prev);
      end
      prev = cur_o;
      if (n == 1)   chk("mute_t1", cur_o, 32509);
      if (n == 254) chk("mute_t254", cur_o, 127);
      if (n == 255) chk("mute_t255", cur_o, 0);
      if (n == 256) chk("mute_t256", cur_o, 0);
    end

    // Phase sync mid-run; ch0 increment changes must not disturb ch1.
    mute_v[0] = 1'b0;
    vol_v[0]  = 8'd100;
    inc_v[0]  = 24'd349525;
    repeat (10) do_tick(1'b0, $urandom_range(0, 3), o);
    inc_v[0] = 24'($urandom);
    do_tick(1'b1, 0, o);
    do_tick(1'b0, 0, o);
    chk("sync_mid", $signed(o[15:0]), 18);

    // Randomized run; ch0 climbs back to unity.
    vol_v[0] = 8'd255;
    for (int n = 0; n < 260; n++) begin
      if ($urandom_range(0, 3) == 0) inc_v[0] = 24'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        inc_v[1]  = 24'($urandom);
        vol_v[1]  = 8'($urandom);
        mute_v[1] = 1'($urandom_range(0, 1));
      end
      do_tick($urandom_range(0, 15) == 0, $urandom_range(0, 3), o);
    end

    // Accumulator wrap: decrement by one per tick across 0.
    do_tick(1'b1, 0, o);
    inc_v[0] = 24'hFFFFFF;
    do_tick(1'b0, 0, o);
    chk("wrap_p0", $signed(o[15:0]), 402);
    do_tick(1'b0, 0, o);
    chk("wrap_pmax", $signed(o[15:0]), -402);
    repeat (5) do_tick(1'b0, $urandom_range(0, 2), o);

    // Quadrant 3, addr 63 at unity.
    do_tick(1'b1, 0, o);
    inc_v[0] = 24'hC00000;
    do_tick(1'b0, 0, o);
    do_tick(1'b0, 0, o);
    chk("q3_addr63", $signed(o[15:0]), -32765);

    // Hold across 100 idle cycles.
    do_tick(1'b0, 0, o);
    repeat (100) begin
      @(posedge clk); #1;
    end
    chk("hold_100", sample, last_exp);

    // Reset with a tick in flight: nothing may emerge afterwards.
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_sample", sample, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_sample_ob", sample_ob, OFFS);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    inc_v[0]  = 24'h400000;
    vol_v[0]  = 8'd255;
    mute_v[0] = 1'b0;
    do_tick(1'b0, 0, o);
    chk("post_rst", $signed(o[15:0]), 1);
    do_tick(1'b0, 2, o);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog got timeout want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
